// File: rtl/dmem_banked_pipe.sv
// Byte-banked data memory with a one-cycle request/response pipeline and a
// bootloader mode that fills whole words while the CPU port is held off.
module dmem_banked_pipe #(
  parameter int unsigned DEPTH_WORDS = 8192,
  parameter int unsigned ADDR_W      = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [2:0]        req_type,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_fault,
  input  logic              debug,
  input  logic              boot_we,
  input  logic [ADDR_W-1:0] boot_addr,
  input  logic [31:0]       boot_wdata,
  output logic [15:0]       boot_cnt
);

  localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);
  localparam logic [ADDR_W-1:0] BYTE_MASK = ADDR_W'(DEPTH_WORDS * 4 - 1);
  localparam logic [ADDR_W-1:0] BOOT_LIM  = ADDR_W'(DEPTH_WORDS);

  localparam logic [0:0] RUN  = 1'b0;
  localparam logic [0:0] BOOT = 1'b1;

  logic [0:0]       state;
  logic             accept;
  logic [IDX_W-1:0] req_idx;
  logic [1:0]       lane;
  logic             type_ok;
  logic             misalign;
  logic             range_err;
  logic             req_fault;
  logic [3:0]       st_lanes;
  logic [31:0]      st_data;
  logic             store_go;
  logic             boot_go;
  logic [3:0]       wr_lanes;
  logic [31:0]      wr_data;
  logic [IDX_W-1:0] wr_idx;

  logic [7:0]       mem [4][DEPTH_WORDS];
  logic [31:0]      rd_word;

  logic             valid_q;
  logic             we_q;
  logic             fault_q;
  logic [2:0]       type_q;
  logic [1:0]       lane_q;
  logic [7:0]       rd_byte;
  logic [15:0]      rd_half;
  logic [31:0]      ext_data;

  assign req_ready = (state == RUN) && !debug && !rst;
  assign accept    = req_valid && req_ready;
  assign req_idx   = req_addr[IDX_W+1:2];
  assign lane      = req_addr[1:0];

  always_comb begin
    type_ok = 1'b0;
    case (req_type)
      3'b000, 3'b001, 3'b010: type_ok = 1'b1;
      3'b100, 3'b101:         type_ok = !req_we;
      default:                type_ok = 1'b0;
    endcase
    misalign  = ((req_type[1:0] == 2'b01) && req_addr[0]) ||
                ((req_type == 3'b010) && (req_addr[1:0] != 2'b00));
    range_err = |(req_addr & ~BYTE_MASK);
    req_fault = !type_ok || misalign || range_err;
  end

  // Store data is replicated across lanes so each bank simply takes its own byte.
  always_comb begin
    st_lanes = '0;
    st_data  = req_wdata;
    case (req_type[1:0])
      2'b00: begin
        st_lanes = 4'b0001 << lane;
        st_data  = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        st_lanes = lane[1] ? 4'b1100 : 4'b0011;
        st_data  = {2{req_wdata[15:0]}};
      end
      default: begin
        st_lanes = '1;
        st_data  = req_wdata;
      end
    endcase
  end

  assign store_go = accept && req_we && !req_fault;
  assign boot_go  = (state == BOOT) && boot_we && (boot_addr < BOOT_LIM) && !rst;
  assign wr_lanes = store_go ? st_lanes : (boot_go ? 4'b1111 : 4'b0000);
  assign wr_data  = boot_go ? boot_wdata : st_data;
  assign wr_idx   = boot_go ? boot_addr[IDX_W-1:0] : req_idx;

  // Read-after-write on the next cycle needs no bypass: the store lands at the
  // edge before the load's synchronous read.
  always_ff @(posedge clk) begin
    for (int unsigned k = 0; k < 4; k++) begin
      if (wr_lanes[k]) mem[k][wr_idx] <= wr_data[k*8 +: 8];
      if (accept)      rd_word[k*8 +: 8] <= mem[k][req_idx];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
    end else begin
      state <= debug ? BOOT : RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      boot_cnt <= '0;
    end else if (state == RUN && debug) begin
      boot_cnt <= '0;
    end else if (boot_go && boot_cnt != 16'hFFFF) begin
      boot_cnt <= boot_cnt + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      we_q    <= 1'b0;
      fault_q <= 1'b0;
      type_q  <= '0;
      lane_q  <= '0;
    end else begin
      valid_q <= accept;
      if (accept) begin
        we_q    <= req_we;
        fault_q <= req_fault;
        type_q  <= req_type;
        lane_q  <= lane;
      end
    end
  end

  always_comb begin
    rd_byte  = 8'(rd_word >> {lane_q, 3'b000});
    rd_half  = lane_q[1] ? rd_word[31:16] : rd_word[15:0];
    ext_data = rd_word;
    case (type_q)
      3'b000:  ext_data = {{24{rd_byte[7]}}, rd_byte};
      3'b100:  ext_data = {24'd0, rd_byte};
      3'b001:  ext_data = {{16{rd_half[15]}}, rd_half};
      3'b101:  ext_data = {16'd0, rd_half};
      default: ext_data = rd_word;
    endcase
  end

  // Gating with rst suppresses the response of a request accepted just before reset.
  assign resp_valid = valid_q && !rst;
  assign resp_fault = valid_q && fault_q && !rst;
  assign resp_rdata = (valid_q && !we_q && !fault_q && !rst) ? ext_data : '0;

endmodule

// File: tb/tb_dmem_banked_pipe.sv
// Scoreboard bench for dmem_banked_pipe: a byte-array model predicts every
// response at issue time; a negedge monitor matches responses against the queue.
module tb_dmem_banked_pipe;

  localparam int unsigned DEPTH = 8192;
  localparam int unsigned LIM   = DEPTH * 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we;
  logic [31:0] req_addr, req_wdata;
  logic [2:0]  req_type;
  logic        resp_valid, resp_fault;
  logic [31:0] resp_rdata;
  logic        debug, boot_we;
  logic [31:0] boot_addr, boot_wdata;
  logic [15:0] boot_cnt;

  typedef struct {
    int unsigned due;
    logic [31:0] data;
    logic        fault;
  } exp_t;

  exp_t        exp_q[$];
  logic [7:0]  mem_m [LIM];
  int unsigned cyc = 0;
  int unsigned checks = 0;
  int unsigned errors = 0;

  dmem_banked_pipe #(.DEPTH_WORDS(DEPTH), .ADDR_W(32)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_type(req_type), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_fault(resp_fault), .debug(debug), .boot_we(boot_we),
    .boot_addr(boot_addr), .boot_wdata(boot_wdata), .boot_cnt(boot_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
      checks++;
      if (resp_valid !== 1'b1 || resp_rdata !== exp_q[0].data || resp_fault !== exp_q[0].fault) begin
        errors++;
        $display("FAIL resp cyc %0d: got valid=%b data=%h fault=%b, expected valid=1 data=%h fault=%b",
                 cyc, resp_valid, resp_rdata, resp_fault, exp_q[0].data, exp_q[0].fault);
      end
      void'(exp_q.pop_front());
    end else begin
      checks++;
      if (resp_valid !== 1'b0) begin
        errors++;
        $display("FAIL idle_valid cyc %0d: got resp_valid=%b expected 0", cyc, resp_valid);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference semantics: little-endian byte memory, natural alignment, extension by type.
  function automatic void model_req(input logic we, input logic [31:0] addr, input logic [2:0] typ,
                                    input logic [31:0] wd, output logic [31:0] d, output logic f);
    int unsigned size;
    logic [31:0] v;
    size = (typ[1:0] == 2'b00) ? 1 : ((typ[1:0] == 2'b01) ? 2 : 4);
    f = !(typ inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    if (we && typ[2]) f = 1'b1;
    if (addr % size != 0) f = 1'b1;
    if (addr >= LIM) f = 1'b1;
    d = '0;
    if (!f) begin
      if (we) begin
        for (int unsigned i = 0; i < size; i++) mem_m[addr + i] = wd[8*i +: 8];
      end else begin
        v = '0;
        for (int unsigned i = 0; i < size; i++) v = v | (32'(mem_m[addr + i]) << (8 * i));
        if (!typ[2] && size == 1) v = {{24{v[7]}}, v[7:0]};
        if (!typ[2] && size == 2) v = {{16{v[15]}}, v[15:0]};
        d = v;
      end
    end
  endfunction

  task automatic issue(input logic we, input logic [31:0] addr, input logic [2:0] typ,
                       input logic [31:0] wd, input bit lit = 1'b0,
                       input logic [31:0] lit_d = '0, input logic lit_f = 1'b0);
    exp_t e;
    logic [31:0] d;
    logic f;
    model_req(we, addr, typ, wd, d, f);
    if (lit) begin
      d = lit_d;
      f = lit_f;
    end
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_type  = typ;
    req_wdata = wd;
    e.due   = cyc + 1;
    e.data  = d;
    e.fault = f;
    exp_q.push_back(e);
    tick();
    req_valid = 1'b0;
  endtask

  task automatic boot_write(input logic [31:0] idx, input logic [31:0] w);
    boot_we    = 1'b1;
    boot_addr  = idx;
    boot_wdata = w;
    if (idx < DEPTH) begin
      for (int unsigned k = 0; k < 4; k++) mem_m[idx*4 + k] = w[8*k +: 8];
    end
    tick();
    boot_we = 1'b0;
  endtask

  initial begin
    logic [31:0] addr, wd, w1;
    logic [2:0]  typ;
    logic        we;
    int unsigned r;

    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
    req_type = '0; debug = 1'b0; boot_we = 1'b0; boot_addr = '0; boot_wdata = '0;
    repeat (2) tick();
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);
    chk("rst_resp_fault", 32'(resp_fault), 32'd0);
    chk("rst_boot_cnt", 32'(boot_cnt), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_req_ready", 32'(req_ready), 32'd1);

    // Fill the whole memory through the bootloader so every model byte is known.
    debug = 1'b1;
    tick();
    chk("boot_req_ready", 32'(req_ready), 32'd0);
    for (int unsigned i = 0; i < DEPTH; i++) boot_write(i, $urandom);
    chk("fill_boot_cnt", 32'(boot_cnt), DEPTH);
    debug = 1'b0;
    tick();
    chk("run_req_ready", 32'(req_ready), 32'd1);

    // Word store then sub-word loads with each extension kind.
    issue(1'b1, 32'h10, 3'b010, 32'hDEADBEEF, 1'b1, 32'h0, 1'b0);
    issue(1'b0, 32'h13, 3'b000, 32'h0, 1'b1, 32'hFFFFFFDE, 1'b0);
    issue(1'b0, 32'h13, 3'b100, 32'h0, 1'b1, 32'h000000DE, 1'b0);
    issue(1'b0, 32'h12, 3'b001, 32'h0, 1'b1, 32'hFFFFDEAD, 1'b0);
    issue(1'b0, 32'h10, 3'b101, 32'h0, 1'b1, 32'h0000BEEF, 1'b0);

    // Byte store immediately followed by a word load of the same word.
    issue(1'b1, 32'h21, 3'b000, 32'hAAAA557F);
    issue(1'b0, 32'h20, 3'b010, 32'h0);

    // Faulting accesses, then confirm the targeted memory was not written.
    issue(1'b0, 32'h01, 3'b001, 32'h0, 1'b1, 32'h0, 1'b1);
    issue(1'b0, 32'h02, 3'b010, 32'h0, 1'b1, 32'h0, 1'b1);
    issue(1'b0, 32'h00, 3'b011, 32'h0, 1'b1, 32'h0, 1'b1);
    issue(1'b1, 32'h30, 3'b100, 32'h12345678, 1'b1, 32'h0, 1'b1);
    issue(1'b1, 32'h8000, 3'b010, 32'hCAFEF00D, 1'b1, 32'h0, 1'b1);
    issue(1'b1, 32'h02, 3'b010, 32'h11223344, 1'b1, 32'h0, 1'b1);
    issue(1'b0, 32'h30, 3'b010, 32'h0);
    issue(1'b0, 32'h00, 3'b010, 32'h0);

    // Bootloader: one out-of-range write is ignored; word 1 becomes visible in RUN.
    debug = 1'b1;
    tick();
    chk("boot2_req_ready", 32'(req_ready), 32'd0);
    w1 = 32'hC0FFEE11;
    boot_write(32'd0, 32'h0BADF00D);
    boot_write(32'd1, w1);
    boot_write(32'd8192, 32'h55555555);
    chk("boot2_cnt", 32'(boot_cnt), 32'd2);
    debug = 1'b0;
    tick();
    chk("boot2_cnt_hold", 32'(boot_cnt), 32'd2);
    issue(1'b0, 32'h4, 3'b010, 32'h0, 1'b1, w1, 1'b0);

    // A load accepted right before reset must never respond.
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h10; req_type = 3'b010;
    tick();
    req_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("rst2_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst2_resp_rdata", resp_rdata, 32'd0);
    tick();
    chk("rst2_resp_fault", 32'(resp_fault), 32'd0);
    chk("rst2_boot_cnt", 32'(boot_cnt), 32'd0);
    rst = 1'b0;
    #1;
    chk("rst2_req_ready", 32'(req_ready), 32'd1);
    tick();
    chk("rst2_no_resp", 32'(resp_valid), 32'd0);

    // Randomized mix of loads/stores, legal and illegal, with random gaps.
    for (int unsigned n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 3) == 0) tick();
      r = $urandom_range(0, 9);
      case (r)
        0, 5:    typ = 3'b000;
        1, 6:    typ = 3'b001;
        2, 7:    typ = 3'b010;
        3:       typ = 3'b100;
        4:       typ = 3'b101;
        default: typ = 3'($urandom_range(0, 7));
      endcase
      we   = 1'($urandom_range(0, 1));
      addr = $urandom_range(0, LIM - 1);
      if ($urandom_range(0, 3) != 0) begin
        if (typ[1:0] == 2'b01) addr[0] = 1'b0;
        if (typ[1:0] == 2'b10) addr[1:0] = 2'b00;
      end
      if ($urandom_range(0, 19) == 0) addr = addr | (32'd1 << $urandom_range(15, 31));
      wd = $urandom;
      issue(we, addr, typ, wd);
    end

    repeat (3) tick();
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
